// File: rtl/issue_scheduler_if.sv
// Issue-scheduler bus: reservation-station readiness and unit class in,
// per-class grants, issue count and unit occupancy out.
interface issue_scheduler_if #(
   parameter int RS_SIZE = 8
);
   logic [RS_SIZE-1:0]   rs_ready;
   logic [2*RS_SIZE-1:0] rs_fu;
   logic                 mem_ack;
   logic [RS_SIZE-1:0]   alu_grant;
   logic [RS_SIZE-1:0]   mult_grant;
   logic [RS_SIZE-1:0]   mem_grant;
   logic [RS_SIZE-1:0]   br_grant;
   logic [2:0]           issue_count;
   logic                 mult_busy;
   logic                 mem_busy;

   modport master (
      output rs_ready, rs_fu, mem_ack,
      input  alu_grant, mult_grant, mem_grant, br_grant, issue_count, mult_busy, mem_busy
   );

   modport slave (
      input  rs_ready, rs_fu, mem_ack,
      output alu_grant, mult_grant, mem_grant, br_grant, issue_count, mult_busy, mem_busy
   );
endinterface

// File: rtl/issue_scheduler.sv
// Per-class round-robin issue scheduler with an issue-width cap, a non-pipelined
// multiplier occupancy counter and a single-outstanding memory unit.
module issue_scheduler #(
   parameter int RS_SIZE     = 8,
   parameter int MULT_LAT    = 4,
   parameter int ISSUE_WIDTH = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              squash,
   issue_scheduler_if.slave  bus
);
   localparam int PW       = $clog2(RS_SIZE);
   localparam int CW       = $clog2(MULT_LAT);
   localparam int CLS_ALU  = 0;
   localparam int CLS_MULT = 1;
   localparam int CLS_MEM  = 2;
   localparam int CLS_BR   = 3;
   localparam logic [RS_SIZE-1:0] GRANT_ONE = {{(RS_SIZE-1){1'b0}}, 1'b1};

   logic [PW-1:0]      ptr_q [4];
   logic [PW-1:0]      ptr_d [4];
   logic [CW-1:0]      mult_cnt_q;
   logic [CW-1:0]      mult_cnt_d;
   logic               mem_busy_q;
   logic               mem_busy_d;
   logic               mult_busy_s;
   logic [3:0]         unit_free_s;
   logic [RS_SIZE-1:0] elig_s  [4];
   logic [RS_SIZE-1:0] grant_s [4];
   logic [PW:0]        pick_s  [4];
   logic [2:0]         cnt_s;

   // {hit, index} of the first set bit at or after ptr, wrapping; the
   // descending scan lets the smallest offset win.
   function automatic logic [PW:0] rr_pick(input logic [RS_SIZE-1:0] elig,
                                           input logic [PW-1:0]      ptr);
      logic [PW:0]   res;
      logic [PW-1:0] idx;
      res = {(PW+1){1'b0}};
      for (int k = RS_SIZE - 1; k >= 0; k--) begin
         idx = ptr + PW'(k);
         res = elig[idx] ? {1'b1, idx} : res;
      end
      return res;
   endfunction

   assign mult_busy_s = (mult_cnt_q != {CW{1'b0}});
   assign unit_free_s = {1'b1, ~mem_busy_q, ~mult_busy_s, 1'b1};

   // Split ready entries by their unit class.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         elig_s[c] = {RS_SIZE{1'b0}};
      end
      for (int i = 0; i < RS_SIZE; i++) begin
         for (int c = 0; c < 4; c++) begin
            elig_s[c][i] = bus.rs_ready[i] & (bus.rs_fu[2*i +: 2] == 2'(c));
         end
      end
   end

   // Arbitration: class code 3 (BR) down to 0 (ALU) is the issue priority order.
   always_comb begin
      cnt_s = 3'd0;
      for (int c = 0; c < 4; c++) begin
         grant_s[c] = {RS_SIZE{1'b0}};
         ptr_d[c]   = ptr_q[c];
         pick_s[c]  = rr_pick(elig_s[c], ptr_q[c]);
      end
      for (int j = 0; j < 4; j++) begin
         if (reset_n && !squash && pick_s[3-j][PW] && unit_free_s[3-j] &&
             (cnt_s < 3'(ISSUE_WIDTH))) begin
            grant_s[3-j] = GRANT_ONE << pick_s[3-j][PW-1:0];
            ptr_d[3-j]   = pick_s[3-j][PW-1:0] + PW'(1'b1);
            cnt_s        = cnt_s + 3'd1;
         end else begin
            cnt_s = cnt_s;
         end
      end
   end

   // Unit occupancy next state; squash abandons both outstanding ops.
   always_comb begin
      mult_cnt_d = mult_cnt_q;
      mem_busy_d = mem_busy_q;
      if (squash) begin
         mult_cnt_d = {CW{1'b0}};
         mem_busy_d = 1'b0;
      end else begin
         if (grant_s[CLS_MULT] != {RS_SIZE{1'b0}}) begin
            mult_cnt_d = CW'(MULT_LAT - 1);
         end else if (mult_busy_s) begin
            mult_cnt_d = mult_cnt_q - CW'(1'b1);
         end else begin
            mult_cnt_d = mult_cnt_q;
         end
         if (grant_s[CLS_MEM] != {RS_SIZE{1'b0}}) begin
            mem_busy_d = 1'b1;
         end else if (mem_busy_q && bus.mem_ack) begin
            mem_busy_d = 1'b0;
         end else begin
            mem_busy_d = mem_busy_q;
         end
      end
   end

   // Arbitration and occupancy state registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < 4; c++) begin
            ptr_q[c] <= {PW{1'b0}};
         end
         mult_cnt_q <= {CW{1'b0}};
         mem_busy_q <= 1'b0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            ptr_q[c] <= ptr_d[c];
         end
         mult_cnt_q <= mult_cnt_d;
         mem_busy_q <= mem_busy_d;
      end
   end

   assign bus.alu_grant   = grant_s[CLS_ALU];
   assign bus.mult_grant  = grant_s[CLS_MULT];
   assign bus.mem_grant   = grant_s[CLS_MEM];
   assign bus.br_grant    = grant_s[CLS_BR];
   assign bus.issue_count = cnt_s;
   assign bus.mult_busy   = mult_busy_s;
   assign bus.mem_busy    = mem_busy_q;
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 4..16).
REQ-002 SHALL have parameter MULT_LAT, default 4, cycles the non-pipelined multiplier stays occupied per op (2..8).
REQ-003 SHALL have parameter ISSUE_WIDTH, default 2, max instructions granted per cycle (1..4).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port squash  input  1  mispredict flush; suppresses issue and clears unit occupancy.
REQ-007 SHALL have port rs_ready  input  RS_SIZE  per-entry valid with both source tags ready.
REQ-008 SHALL have port rs_fu  input  2*RS_SIZE  per-entry unit class, entry i in bits [2i+1:2i]: 0 ALU, 1 MULT, 2 MEM, 3 BR.
REQ-009 SHALL have port mem_ack  input  1  memory unit finished its outstanding op.
REQ-010 SHALL have ports alu_grant, mult_grant, mem_grant, br_grant  output  RS_SIZE each  one-hot or zero selected entry per class; drives issue_en of that entry.
REQ-011 SHALL have port issue_count  output  3  number of grants asserted this cycle.
REQ-012 SHALL have ports mult_busy, mem_busy  output  1 each  unit occupied; class not grantable.

Function
REQ-013 Grants SHALL be combinational from current state and inputs; arbitration state SHALL update at the rising edge.
REQ-014 Entry i SHALL be eligible for class C only when rs_ready[i]=1 and rs_fu entry i = C; no entry can be granted in two classes.
REQ-015 Each class SHALL keep a round-robin pointer; candidate = first eligible entry at index >= pointer, ascending, wrapping past RS_SIZE-1 to 0.
REQ-016 MULT SHALL be grantable only when mult_busy=0; MEM only when mem_busy=0; ALU and BR always grantable.
REQ-017 Width limit: classes SHALL be considered in priority BR, MEM, MULT, ALU; once ISSUE_WIDTH grants exist, remaining classes SHALL output zero that cycle.
REQ-018 On a grant at index i, that class pointer SHALL become (i+1) mod RS_SIZE next cycle; ungranted class pointers (incl. width-blocked) SHALL hold.
REQ-019 Multiplier counter: on MULT grant load MULT_LAT-1; otherwise decrement if nonzero; mult_busy = (counter != 0); a second MULT grant is possible exactly MULT_LAT cycles after the first.
REQ-020 mem_busy SHALL set the cycle after a MEM grant and clear the cycle after mem_ack while busy; mem_ack while not busy SHALL be ignored; no MEM grant in the same cycle mem_ack clears busy.
REQ-021 squash=1 SHALL force all grants and issue_count to 0 that cycle, and next cycle counter=0, mem_busy=0; pointers SHALL hold.
REQ-022 issue_count SHALL equal the popcount of all four grant vectors, never exceeding ISSUE_WIDTH.
REQ-023 No ready entries SHALL yield all-zero grants with state unchanged except counter decrement.

Reset
REQ-024 While reset_n=0, all grants and issue_count SHALL be 0 immediately (asynchronously).
REQ-025 Reset SHALL set all pointers to 0, multiplier counter to 0, mem_busy to 0, so mult_busy=mem_busy=0.
REQ-026 Reset asserted mid-multiply or mid-memory-op SHALL abandon occupancy; first cycle after release all classes are grantable.

Verification
REQ-027 Reset release, rs_ready=8'b0000_0110, both ALU -> alu_grant=0000_0010 cycle 0, 0000_0100 cycle 1 (pointer advanced to 2), issue_count=1 each.
REQ-028 ISSUE_WIDTH=2, entries 0 BR, 1 MEM, 2 MULT, 3 ALU all ready -> br_grant=0001, mem_grant=0010, mult/alu zero, issue_count=2; MULT/ALU pointers unchanged.
REQ-029 MULT grant at cycle 0, another MULT entry held ready -> mult_busy=1 cycles 1-3, next mult_grant cycle 4 (MULT_LAT=4).
REQ-030 MEM grant cycle 0, mem_ack cycle 3 -> mem_busy=1 cycles 1-3, no MEM grant cycles 1-3, next MEM grant cycle 4.
REQ-031 squash during mult_busy=1 and mem_busy=1 with ready entries -> all grants 0 that cycle, both busy flags 0 next cycle, grants resume next cycle.
REQ-032 Pointer at RS_SIZE-1, ready only entries 0 and 7 of ALU class, pointer=7 -> grant 7, then wrap to grant 0.
